// File: rtl/alu_pkg.sv
// Shared ALU definitions: slice width, sequencer state encoding and an
// elaboration-time log2 helper used for ID and word-index widths.
package alu_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Smallest r with 2**r >= n.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/add16_ci.sv
// 16-bit carry-lookahead adder slice: four 4-bit lookahead groups feeding
// a group-level lookahead unit.
module add16_ci
    import alu_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_ci,
    output logic [WORD_W-1:0] o_sum,
    output logic              o_co
);

    localparam int unsigned NGRP = 4;

    logic [WORD_W-1:0] w_g;
    logic [WORD_W-1:0] w_p;
    logic [WORD_W-1:0] w_c;
    logic [NGRP-1:0]   w_gg;
    logic [NGRP-1:0]   w_gp;
    logic [NGRP:0]     w_gc;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Group generate/propagate.
    always_comb begin
        w_gg = '0;
        w_gp = '0;
        for (int k = 0; k < NGRP; k++) begin
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_gp[k] = &w_p[4*k +: 4];
        end
    end

    // Group-level lookahead: every group carry-in straight from i_ci.
    always_comb begin
        w_gc    = '0;
        w_gc[0] = i_ci;
        w_gc[1] = w_gg[0] | (w_gp[0] & i_ci);
        w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_ci);
        w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                | (w_gp[2] & w_gp[1] & w_gp[0] & i_ci);
        w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_ci);
    end

    // Bit carries inside each group.
    always_comb begin
        w_c = '0;
        for (int k = 0; k < NGRP; k++) begin
            w_c[4*k]   = w_gc[k];
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
        end
    end

    assign o_sum = w_p ^ w_c;
    assign o_co  = w_gc[NGRP];

endmodule

// File: rtl/add_arbiter_seq.sv
// Round-robin arbiter sharing one 16-bit CLA slice across NREQ requesters;
// each multi-word add/sub is sequenced LSW first with the carry chained.
module add_arbiter_seq
    import alu_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*WORD_W*WORDS-1:0]  req_a,
    input  logic [NREQ*WORD_W*WORDS-1:0]  req_b,
    input  logic [NREQ-1:0]               req_sub,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [clog2(NREQ)-1:0]        rsp_id,
    output logic [WORD_W*WORDS-1:0]       rsp_sum,
    output logic                          rsp_carry
);

    localparam int unsigned ID_W   = clog2(NREQ);
    localparam int unsigned OP_W   = WORD_W * WORDS;
    localparam int unsigned WIDX_W = (WORDS > 1) ? clog2(WORDS) : 1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   w_grant;
    logic              w_accept;
    logic [WIDX_W-1:0] r_word_idx;
    logic              w_last_word;
    logic              r_carry;
    logic              r_rsp_valid;
    logic [OP_W-1:0]   r_a;
    logic [OP_W-1:0]   r_b;
    logic [OP_W-1:0]   r_result;
    logic [OP_W-1:0]   w_sel_a;
    logic [OP_W-1:0]   w_sel_b;
    logic [WORD_W-1:0] w_a_word;
    logic [WORD_W-1:0] w_b_word;
    logic [WORD_W-1:0] w_sum_word;
    logic              w_cout;

    assign w_last_word = (r_word_idx == WIDX_W'(WORDS - 1));

    // Next state, round-robin grant and the combinational accept strobe.
    always_comb begin
        logic        found;
        int unsigned idx;
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_grant     = '0;
        req_ready   = '0;
        found       = 1'b0;
        idx         = 0;
        case (r_state)
            ST_IDLE: begin
                if (!rst) begin
                    for (int unsigned k = 0; k < NREQ; k++) begin
                        idx = 32'(r_rr_ptr) + k;
                        if (idx >= NREQ) idx = idx - NREQ;
                        if (!found && req_valid[ID_W'(idx)]) begin
                            found   = 1'b1;
                            w_grant = ID_W'(idx);
                        end
                    end
                    if (found) begin
                        req_ready[w_grant] = 1'b1;
                        w_accept           = 1'b1;
                        w_state_nxt        = ST_BUSY;
                    end
                end
            end
            ST_BUSY: if (w_last_word) w_state_nxt = ST_DONE;
            ST_DONE: if (rsp_ready)   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand select for the granted requester.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == w_grant) begin
                w_sel_a = req_a[i*OP_W +: OP_W];
                w_sel_b = req_b[i*OP_W +: OP_W];
            end
        end
    end

    // Word multiplexer feeding the shared slice.
    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int unsigned j = 0; j < WORDS; j++) begin
            if (WIDX_W'(j) == r_word_idx) begin
                w_a_word = r_a[j*WORD_W +: WORD_W];
                w_b_word = r_b[j*WORD_W +: WORD_W];
            end
        end
    end

    add16_ci u_slice (
        .i_a   (w_a_word),
        .i_b   (w_b_word),
        .i_ci  (r_carry),
        .o_sum (w_sum_word),
        .o_co  (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_word_idx  <= '0;
            r_carry     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a        <= w_sel_a;
                        r_b        <= req_sub[w_grant] ? ~w_sel_b : w_sel_b;
                        r_carry    <= req_sub[w_grant];
                        r_id       <= w_grant;
                        r_word_idx <= '0;
                        r_rr_ptr   <= (w_grant == ID_W'(NREQ - 1)) ? '0
                                                                   : w_grant + ID_W'(1);
                    end
                end
                ST_BUSY: begin
                    for (int unsigned j = 0; j < WORDS; j++) begin
                        if (WIDX_W'(j) == r_word_idx)
                            r_result[j*WORD_W +: WORD_W] <= w_sum_word;
                    end
                    r_carry    <= w_cout;
                    r_word_idx <= r_word_idx + WIDX_W'(1);
                    if (w_last_word) r_rsp_valid <= 1'b1;
                end
                ST_DONE: if (rsp_ready) r_rsp_valid <= 1'b0;
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_sum   = r_result;
    assign rsp_carry = r_carry;

endmodule
